switch_collector: RTL and testbench

Input-side counterpart of the board's LED fan-out: collects eight raw slide-switch/button inputs, synchronizes and debounces each, and reduces them to one registered level plus a one-cycle change pulse. Sits between the board switches and the control logic that drives the light outputs. All logic runs on one clock; there are no handshakes.

---
 rtl/switch_collector_pkg.sv | 16 +
 rtl/switch_debouncer.sv | 45 ++++
 rtl/switch_collector.sv | 50 +++++
 tb/tb_switch_collector.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/switch_collector_pkg.sv
// Shared constants and helpers for the switch collector:
// default widths, reduction-mode encodings and the debounce counter sizing.
package switch_collector_pkg;

  localparam int unsigned WIDTH_DEF     = 8;
  localparam int unsigned DB_CYCLES_DEF = 16;

  localparam logic MODE_ANY = 1'b0;
  localparam logic MODE_ALL = 1'b1;

  // Counter only has to reach DB_CYCLES-1; keep at least one bit so DB_CYCLES=1 still elaborates.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/switch_debouncer.sv
// One switch bit: two-flop synchronizer, then a level that is accepted only
// after DB_CYCLES consecutive disagreeing synchronized samples.
module switch_debouncer
  import switch_collector_pkg::*;
#(
  parameter int unsigned DB_CYCLES = DB_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_raw,
  output logic o_stable
);

  localparam int unsigned    CW   = cnt_width(DB_CYCLES);
  localparam logic [CW-1:0]  LAST = CW'(DB_CYCLES - 1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_stable;
  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1  <= 1'b0;
      r_sync2  <= 1'b0;
      r_stable <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
      // Any sample agreeing with the accepted level restarts the qualification window.
      if (r_sync2 == r_stable) begin
        r_cnt <= '0;
      end else if (r_cnt == LAST) begin
        r_stable <= r_sync2;
        r_cnt    <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_stable = r_stable;

endmodule

// File: rtl/switch_collector.sv
// Debounces WIDTH raw switches and reduces them (OR or AND, chosen by mode)
// to one registered level with a one-cycle pulse on every toggle.
module switch_collector
  import switch_collector_pkg::*;
#(
  parameter int unsigned WIDTH     = WIDTH_DEF,
  parameter int unsigned DB_CYCLES = DB_CYCLES_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] i,
  input  logic             mode,
  output logic             o,
  output logic [WIDTH-1:0] stable,
  output logic             changed
);

  logic [WIDTH-1:0] w_stable;
  logic             w_next_o;
  logic             r_o;
  logic             r_changed;

  for (genvar k = 0; k < WIDTH; k++) begin : g_db
    switch_debouncer #(
      .DB_CYCLES (DB_CYCLES)
    ) u_db (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_raw    (i[k]),
      .o_stable (w_stable[k])
    );
  end

  assign w_next_o = (mode == MODE_ALL) ? (&w_stable) : (|w_stable);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_o       <= 1'b0;
      r_changed <= 1'b0;
    end else begin
      r_o       <= w_next_o;
      r_changed <= (w_next_o != r_o);
    end
  end

  assign o       = r_o;
  assign stable  = w_stable;
  assign changed = r_changed;

endmodule

// File: tb/tb_switch_collector.sv
// Scoreboard bench for switch_collector with DB_CYCLES=4: per-edge expected
// (stable, o, changed) triples are queued with the stimulus and popped after each edge.
module tb_switch_collector;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] i;
  logic       mode;
  logic       o;
  logic [7:0] stable;
  logic       changed;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] st;
    logic       o;
    logic       ch;
  } exp_t;

  exp_t sb[$];
  exp_t e;

  switch_collector #(
    .WIDTH     (8),
    .DB_CYCLES (4)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .i       (i),
    .mode    (mode),
    .o       (o),
    .stable  (stable),
    .changed (changed)
  );

  always #5 clk = ~clk;

  task automatic push(input logic [7:0] st, input logic ov, input logic ch, input int n);
    exp_t x;
    x.st = st; x.o = ov; x.ch = ch;
    repeat (n) sb.push_back(x);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; i = 8'hFF; mode = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (stable !== 8'h00 || o !== 1'b0 || changed !== 1'b0) begin
      errors++;
      $display("FAIL reset_hold: stable=%h o=%b changed=%b, required 00/0/0", stable, o, changed);
    end
    rst_n = 1'b1;
    push(8'h00, 0, 0, 5); push(8'hFF, 0, 0, 1); push(8'hFF, 1, 1, 1); push(8'hFF, 1, 0, 1);
    for (int j = 0; j < 8; j++) begin
      @(posedge clk); #1;
      e = sb.pop_front(); checks++;
      if (stable !== e.st || o !== e.o || changed !== e.ch) begin
        errors++;
        $display("FAIL reset_release edge %0d: stable=%h o=%b changed=%b, required %h/%b/%b",
                 j, stable, o, changed, e.st, e.o, e.ch);
      end
    end
  endtask

  task automatic test_any_rise();
    mode = 1'b0; i = 8'h00;
    push(8'hFF, 1, 0, 5); push(8'h00, 1, 0, 1); push(8'h00, 0, 1, 1); push(8'h00, 0, 0, 1);
    push(8'h00, 0, 0, 5); push(8'h01, 0, 0, 1); push(8'h01, 1, 1, 1); push(8'h01, 1, 0, 1);
    for (int j = 0; j < 16; j++) begin
      @(posedge clk); #1;
      e = sb.pop_front(); checks++;
      if (stable !== e.st || o !== e.o || changed !== e.ch) begin
        errors++;
        $display("FAIL any_rise step %0d: stable=%h o=%b changed=%b, required %h/%b/%b",
                 j, stable, o, changed, e.st, e.o, e.ch);
      end
      if (j == 7) i = 8'h01;
    end
  endtask

  task automatic test_glitch();
    i = 8'h00;
    push(8'h01, 1, 0, 5); push(8'h00, 1, 0, 1); push(8'h00, 0, 1, 1); push(8'h00, 0, 0, 1);
    for (int j = 0; j < 8; j++) begin
      @(posedge clk); #1;
      e = sb.pop_front(); checks++;
      if (stable !== e.st || o !== e.o || changed !== e.ch) begin
        errors++;
        $display("FAIL glitch_clear step %0d: stable=%h o=%b changed=%b, required %h/%b/%b",
                 j, stable, o, changed, e.st, e.o, e.ch);
      end
    end
    // three-cycle pulse must be rejected
    i = 8'h08;
    push(8'h00, 0, 0, 10);
    for (int j = 0; j < 10; j++) begin
      @(posedge clk); #1;
      e = sb.pop_front(); checks++;
      if (stable !== e.st || o !== e.o || changed !== e.ch) begin
        errors++;
        $display("FAIL glitch_short step %0d: stable=%h o=%b changed=%b, required %h/%b/%b",
                 j, stable, o, changed, e.st, e.o, e.ch);
      end
      if (j == 2) i = 8'h00;
    end
    // four-cycle pulse is accepted, then released again by the trailing low
    i = 8'h08;
    push(8'h00, 0, 0, 5); push(8'h08, 0, 0, 1); push(8'h08, 1, 1, 1); push(8'h08, 1, 0, 2);
    push(8'h00, 1, 0, 1); push(8'h00, 0, 1, 1); push(8'h00, 0, 0, 1);
    for (int j = 0; j < 12; j++) begin
      @(posedge clk); #1;
      e = sb.pop_front(); checks++;
      if (stable !== e.st || o !== e.o || changed !== e.ch) begin
        errors++;
        $display("FAIL glitch_min step %0d: stable=%h o=%b changed=%b, required %h/%b/%b",
                 j, stable, o, changed, e.st, e.o, e.ch);
      end
      if (j == 3) i = 8'h00;
    end
  endtask

  task automatic test_all_drop();
    mode = 1'b1; i = 8'hFF;
    push(8'h00, 0, 0, 5); push(8'hFF, 0, 0, 1); push(8'hFF, 1, 1, 1); push(8'hFF, 1, 0, 1);
    push(8'hFF, 1, 0, 5); push(8'hDF, 1, 0, 1); push(8'hDF, 0, 1, 1); push(8'hDF, 0, 0, 1);
    for (int j = 0; j < 16; j++) begin
      @(posedge clk); #1;
      e = sb.pop_front(); checks++;
      if (stable !== e.st || o !== e.o || changed !== e.ch) begin
        errors++;
        $display("FAIL all_drop step %0d: stable=%h o=%b changed=%b, required %h/%b/%b",
                 j, stable, o, changed, e.st, e.o, e.ch);
      end
      if (j == 7) i = 8'hDF;
    end
  endtask

  task automatic test_mode();
    mode = 1'b0; i = 8'h0F;
    push(8'hDF, 1, 1, 1); push(8'hDF, 1, 0, 4); push(8'h0F, 1, 0, 3);
    push(8'h0F, 0, 1, 1); push(8'h0F, 0, 0, 2);
    push(8'h0F, 1, 1, 1); push(8'h0F, 1, 0, 2);
    for (int j = 0; j < 14; j++) begin
      @(posedge clk); #1;
      e = sb.pop_front(); checks++;
      if (stable !== e.st || o !== e.o || changed !== e.ch) begin
        errors++;
        $display("FAIL mode_switch step %0d: stable=%h o=%b changed=%b, required %h/%b/%b",
                 j, stable, o, changed, e.st, e.o, e.ch);
      end
      if (j == 7)  mode = 1'b1;
      if (j == 10) mode = 1'b0;
    end
  endtask

  task automatic test_reset_mid();
    i = 8'hFF;
    push(8'h0F, 1, 0, 4);
    for (int j = 0; j < 4; j++) begin
      @(posedge clk); #1;
      e = sb.pop_front(); checks++;
      if (stable !== e.st || o !== e.o || changed !== e.ch) begin
        errors++;
        $display("FAIL reset_mid_pre step %0d: stable=%h o=%b changed=%b, required %h/%b/%b",
                 j, stable, o, changed, e.st, e.o, e.ch);
      end
    end
    rst_n = 1'b0;
    #2;
    checks++;
    if (stable !== 8'h00 || o !== 1'b0 || changed !== 1'b0) begin
      errors++;
      $display("FAIL reset_async: stable=%h o=%b changed=%b, required 00/0/0", stable, o, changed);
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    push(8'h00, 0, 0, 5); push(8'hFF, 0, 0, 1); push(8'hFF, 1, 1, 1); push(8'hFF, 1, 0, 1);
    for (int j = 0; j < 8; j++) begin
      @(posedge clk); #1;
      e = sb.pop_front(); checks++;
      if (stable !== e.st || o !== e.o || changed !== e.ch) begin
        errors++;
        $display("FAIL reset_mid_post edge %0d: stable=%h o=%b changed=%b, required %h/%b/%b",
                 j, stable, o, changed, e.st, e.o, e.ch);
      end
    end
  endtask

  initial begin
    test_reset();
    test_any_rise();
    test_glitch();
    test_all_drop();
    test_mode();
    test_reset_mid();
    checks++;
    if (sb.size() !== 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
